// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a zero-latency ROM and queues
// {pc, inst} pairs for decode behind a valid/ready handshake, with redirect and halt.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    output logic        IF_Valid,
    input  logic        IF_Ready,
    output logic [31:0] IF_Inst,
    output logic [31:0] IF_PC,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    input  logic        Halt,
    output logic [31:0] Fetch_Cnt
);

    // DEPTH is 2 or 4, so pointers wrap naturally at the power-of-two boundary.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [31:0]      PC_RESET  = {RESET_PC[31:2], 2'b00};

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_cnt_q, fetch_cnt_d;
    logic [31:0]      q_inst_q [DEPTH];
    logic [31:0]      q_inst_d [DEPTH];
    logic [31:0]      q_pc_q   [DEPTH];
    logic [31:0]      q_pc_d   [DEPTH];

    logic pop;
    logic fetch;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^Redirect_PC[1:0];

    assign Addr      = pc_q;
    assign IF_Valid  = (count_q != '0);
    assign IF_Inst   = IF_Valid ? q_inst_q[rd_ptr_q] : 32'h0;
    assign IF_PC     = IF_Valid ? q_pc_q[rd_ptr_q]   : 32'h0;
    assign Fetch_Cnt = fetch_cnt_q;

    always_comb begin
        pop   = IF_Valid & IF_Ready;
        fetch = ~Redirect & ~Halt & ((count_q < FULL_CNT) | pop);

        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fetch_cnt_d = fetch_cnt_q;
        q_inst_d    = q_inst_q;
        q_pc_d      = q_pc_q;

        if (Redirect) begin
            // A coincident pop is still consumed by decode; the flush wins for the queue.
            pc_d     = {Redirect_PC[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch) begin
                q_inst_d[wr_ptr_q] = Inst;
                q_pc_d[wr_ptr_q]   = pc_q;
                wr_ptr_d           = wr_ptr_q + 1'b1;
                pc_d               = pc_q + 32'd4;
                fetch_cnt_d        = fetch_cnt_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({fetch, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_q        <= PC_RESET;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fetch_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fetch_cnt_q <= fetch_cnt_d;
            q_inst_q    <= q_inst_d;
            q_pc_q      <= q_pc_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: scoreboard of expected decode pops plus directed
// cycle checks on PC, valid and fetch count.
module tb_inst_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        Clk;
    logic        Clrn;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        IF_Valid;
    logic        IF_Ready;
    logic [31:0] IF_Inst;
    logic [31:0] IF_PC;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Halt;
    logic [31:0] Fetch_Cnt;

    logic [31:0] w_addr;
    logic [31:0] w_inst;
    logic        w_valid;
    logic [31:0] w_if_inst;
    logic [31:0] w_if_pc;
    logic [31:0] w_fetch_cnt;
    logic        w_zero;
    logic [31:0] w_zero32;

    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h3401_000A;
            32'h0000_0004: rom_word = 32'h2002_0006;
            32'h0000_0030: rom_word = 32'h1022_0004;
            default:       rom_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign Inst   = rom_word(Addr);
    assign w_inst = rom_word(w_addr);

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .Clk(Clk), .Clrn(Clrn), .Addr(Addr), .Inst(Inst),
        .IF_Valid(IF_Valid), .IF_Ready(IF_Ready), .IF_Inst(IF_Inst), .IF_PC(IF_PC),
        .Redirect(Redirect), .Redirect_PC(Redirect_PC), .Halt(Halt), .Fetch_Cnt(Fetch_Cnt)
    );

    inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .Clk(Clk), .Clrn(Clrn), .Addr(w_addr), .Inst(w_inst),
        .IF_Valid(w_valid), .IF_Ready(IF_Ready), .IF_Inst(w_if_inst), .IF_PC(w_if_pc),
        .Redirect(w_zero), .Redirect_PC(w_zero32), .Halt(w_zero), .Fetch_Cnt(w_fetch_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_pop(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        sb_q.push_back(e);
    endtask

    task automatic chk_drained(input string name);
        chk(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Monitor: every accepted head must match the next expected pop.
    always @(negedge Clk) begin
        exp_t e;
        if (Clrn && IF_Valid && IF_Ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got pc %h expected no pop", IF_PC);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", IF_PC, e.pc);
                chk("sb_inst", IF_Inst, e.inst);
            end
        end
    end

    // Enters with Clrn=0, IF_Ready=1, Halt=0, Redirect=0; leaves with Clrn=0.
    task automatic run_startup(input string tag);
        cyc();
        chk({tag, "_rst_addr"}, Addr, 32'h0);
        chk({tag, "_rst_valid"}, {31'b0, IF_Valid}, 32'h0);
        chk({tag, "_rst_inst"}, IF_Inst, 32'h0);
        chk({tag, "_rst_pc"}, IF_PC, 32'h0);
        chk({tag, "_rst_cnt"}, Fetch_Cnt, 32'h0);
        expect_pop(32'h0, 32'h3401_000A);
        expect_pop(32'h4, 32'h2002_0006);
        Clrn = 1'b1;
        chk({tag, "_c0_addr"}, Addr, 32'h0);
        chk({tag, "_c0_valid"}, {31'b0, IF_Valid}, 32'h0);
        cyc();
        chk({tag, "_c1_valid"}, {31'b0, IF_Valid}, 32'h1);
        chk({tag, "_c1_pc"}, IF_PC, 32'h0);
        chk({tag, "_c1_inst"}, IF_Inst, 32'h3401_000A);
        chk({tag, "_wrap_c1_pc"}, w_if_pc, 32'hFFFF_FFF8);
        cyc();
        chk({tag, "_c2_pc"}, IF_PC, 32'h4);
        chk({tag, "_c2_inst"}, IF_Inst, 32'h2002_0006);
        chk({tag, "_c2_cnt"}, Fetch_Cnt, 32'd2);
        chk({tag, "_wrap_c2_pc"}, w_if_pc, 32'hFFFF_FFFC);
        cyc();
        chk({tag, "_c3_pc"}, IF_PC, 32'h8);
        chk({tag, "_wrap_c3_pc"}, w_if_pc, 32'h0000_0000);
        chk({tag, "_wrap_c3_inst"}, w_if_inst, 32'h3401_000A);
        Clrn = 1'b0;
        chk_drained({tag, "_sb_drained"});
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        Clrn        = 1'b0;
        IF_Ready    = 1'b1;
        Redirect    = 1'b0;
        Redirect_PC = 32'h0;
        Halt        = 1'b0;
        w_zero      = 1'b0;
        w_zero32    = 32'h0;

        run_startup("s1");

        // Backpressure from reset: queue fills with PC 0 and 4, then streams.
        IF_Ready = 1'b0;
        cyc();
        Clrn = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c >= 2) begin
                chk("bp_addr", Addr, 32'h8);
                chk("bp_cnt", Fetch_Cnt, 32'd2);
                chk("bp_inst", IF_Inst, 32'h3401_000A);
                chk("bp_pc", IF_PC, 32'h0);
            end
        end
        for (int k = 0; k < 5; k++) expect_pop(32'(4 * k), rom_word(32'(4 * k)));
        for (int c = 5; c <= 9; c++) begin
            cyc();
            IF_Ready = 1'b1;
            chk("stream_valid", {31'b0, IF_Valid}, 32'h1);
        end
        cyc();
        IF_Ready = 1'b0;
        chk_drained("stream_sb_drained");
        chk("stream_cnt", Fetch_Cnt, 32'd7);
        chk("stream_head", IF_PC, 32'h14);

        // Redirect with a full queue, then a misaligned target.
        Redirect    = 1'b1;
        Redirect_PC = 32'h30;
        cyc();
        Redirect = 1'b0;
        chk("redir_valid", {31'b0, IF_Valid}, 32'h0);
        chk("redir_addr", Addr, 32'h30);
        chk("redir_cnt", Fetch_Cnt, 32'd7);
        cyc();
        chk("redir_head_valid", {31'b0, IF_Valid}, 32'h1);
        chk("redir_head_pc", IF_PC, 32'h30);
        chk("redir_head_inst", IF_Inst, 32'h1022_0004);
        cyc();
        Redirect    = 1'b1;
        Redirect_PC = 32'h33;
        cyc();
        Redirect = 1'b0;
        chk("mis_valid", {31'b0, IF_Valid}, 32'h0);
        chk("mis_addr", Addr, 32'h30);
        cyc();
        chk("mis_head_pc", IF_PC, 32'h30);
        chk("mis_head_inst", IF_Inst, 32'h1022_0004);

        // Redirect with a simultaneous pop while halted.
        cyc();
        chk("rh_pre_addr", Addr, 32'h38);
        expect_pop(32'h30, 32'h1022_0004);
        IF_Ready    = 1'b1;
        Halt        = 1'b1;
        Redirect    = 1'b1;
        Redirect_PC = 32'h40;
        cyc();
        Redirect = 1'b0;
        chk("rh_valid", {31'b0, IF_Valid}, 32'h0);
        chk("rh_addr", Addr, 32'h40);
        chk("rh_cnt", Fetch_Cnt, 32'd11);
        chk_drained("rh_sb_drained");
        cyc();
        chk("rh_hold_valid", {31'b0, IF_Valid}, 32'h0);
        chk("rh_hold_addr", Addr, 32'h40);
        Halt = 1'b0;
        expect_pop(32'h40, rom_word(32'h40));
        cyc();
        chk("rh_resume_valid", {31'b0, IF_Valid}, 32'h1);
        chk("rh_resume_pc", IF_PC, 32'h40);
        IF_Ready = 1'b0;

        // Halt with a full queue drains it while PC and count hold.
        cyc();
        chk("halt_pre_cnt", Fetch_Cnt, 32'd13);
        chk("halt_pre_addr", Addr, 32'h48);
        chk("halt_pre_valid", {31'b0, IF_Valid}, 32'h1);
        Halt     = 1'b1;
        IF_Ready = 1'b1;
        expect_pop(32'h44, rom_word(32'h44));
        expect_pop(32'h48, rom_word(32'h48));
        cyc();
        chk("halt_d1_pc", IF_PC, 32'h44);
        chk("halt_d1_addr", Addr, 32'h48);
        cyc();
        chk("halt_empty_valid", {31'b0, IF_Valid}, 32'h0);
        chk("halt_empty_addr", Addr, 32'h48);
        chk("halt_empty_cnt", Fetch_Cnt, 32'd13);
        cyc();
        chk("halt_end_valid", {31'b0, IF_Valid}, 32'h0);
        chk("halt_end_addr", Addr, 32'h48);
        Halt = 1'b0;
        cyc();
        chk("unhalt_valid", {31'b0, IF_Valid}, 32'h1);
        chk("unhalt_pc", IF_PC, 32'h48);
        chk("unhalt_cnt", Fetch_Cnt, 32'd14);
        cyc();
        chk("pre_arst_pc", IF_PC, 32'h4C);
        chk("pre_arst_cnt", Fetch_Cnt, 32'd15);
        chk("pre_arst_addr", Addr, 32'h50);

        // Asynchronous reset between edges, then the startup sequence again.
        #2;
        Clrn = 1'b0;
        #1;
        chk("arst_valid", {31'b0, IF_Valid}, 32'h0);
        chk("arst_addr", Addr, 32'h0);
        chk("arst_cnt", Fetch_Cnt, 32'h0);
        chk("arst_pc", IF_PC, 32'h0);
        chk_drained("arst_sb_drained");
        run_startup("s6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
